// File: rtl/enemy_hit_manager.sv
// Enemy target: counts each projectile hit once per flight, tracks hit points,
// and runs the advance / explode / respawn life cycle with registered outputs.
module enemy_hit_manager #(
  parameter int ENEMY_HP       = 3,
  parameter int DIVIDER        = 60_000,
  parameter int EXPLODE_CYCLES = 25_000_000,
  parameter int SCREEN_WIDTH   = 640,
  parameter int SPAWN_Y        = 200,
  parameter int WIDTH_ENEMY    = 64
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               restart_enemy,
  input  logic               collision_light_1,
  input  logic               collision_light_2,
  input  logic               collision_light_3,
  input  logic               in_air_1,
  input  logic               in_air_2,
  input  logic               in_air_3,
  output logic signed [31:0] topLeft_x_enemy,
  output logic        [31:0] topLeft_y_enemy,
  output logic        [2:0]  enemy_hp,
  output logic               enemy_alive,
  output logic               exploding,
  output logic               hit_pulse,
  output logic               kill_pulse
);

  localparam int MOVE_W  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int EXPL_W  = (EXPLODE_CYCLES > 1) ? $clog2(EXPLODE_CYCLES) : 1;
  localparam int X_LIMIT = -WIDTH_ENEMY;

  typedef enum logic [1:0] {
    ST_ALIVE   = 2'd0,
    ST_EXPLODE = 2'd1,
    ST_RESPAWN = 2'd2
  } state_t;

  function automatic logic [1:0] count_hits(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  state_t                    state_r;
  logic        [MOVE_W-1:0]  move_cnt_r;
  logic        [EXPL_W-1:0]  expl_cnt_r;
  logic signed [31:0]        x_r;
  logic        [2:0]         hp_r;
  logic                      alive_r;
  logic                      exploding_r;
  logic                      hit_pulse_r;
  logic                      kill_pulse_r;
  logic        [2:0]         hit_seen_r;

  logic [2:0] coll_s;
  logic [2:0] air_s;
  logic [2:0] new_hit_s;
  logic [1:0] n_hits_s;
  logic       kill_s;

  assign coll_s    = {collision_light_3, collision_light_2, collision_light_1};
  assign air_s     = {in_air_3, in_air_2, in_air_1};
  assign new_hit_s = coll_s & air_s & ~hit_seen_r;
  assign n_hits_s  = count_hits(new_hit_s);
  // hp is never 0 while alive, so a non-zero hit count is required to kill
  assign kill_s    = (n_hits_s != 2'd0) && ({1'b0, n_hits_s} >= hp_r);

  // Life-cycle state, hit latches, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!resetN || restart_enemy) begin
      state_r      <= ST_ALIVE;
      move_cnt_r   <= MOVE_W'(0);
      expl_cnt_r   <= EXPL_W'(0);
      x_r          <= SCREEN_WIDTH;
      hp_r         <= 3'(ENEMY_HP);
      alive_r      <= 1'b1;
      exploding_r  <= 1'b0;
      hit_pulse_r  <= 1'b0;
      kill_pulse_r <= 1'b0;
      hit_seen_r   <= 3'b000;
    end else begin
      hit_pulse_r  <= 1'b0;
      kill_pulse_r <= 1'b0;
      hit_seen_r   <= (hit_seen_r | (coll_s & air_s)) & air_s;
      case (state_r)
        ST_ALIVE: begin
          if (kill_s) begin
            hp_r         <= 3'd0;
            kill_pulse_r <= 1'b1;
            state_r      <= ST_EXPLODE;
            alive_r      <= 1'b0;
            exploding_r  <= 1'b1;
            expl_cnt_r   <= EXPL_W'(0);
          end else begin
            if (n_hits_s != 2'd0) begin
              hp_r        <= hp_r - {1'b0, n_hits_s};
              hit_pulse_r <= 1'b1;
            end
            if (move_cnt_r == MOVE_W'(DIVIDER - 1)) begin
              move_cnt_r <= MOVE_W'(0);
              x_r        <= x_r - 32'sd1;
            end else begin
              move_cnt_r <= move_cnt_r + MOVE_W'(1);
            end
            if (x_r <= X_LIMIT) begin
              state_r <= ST_RESPAWN;
              alive_r <= 1'b0;
            end
          end
        end
        ST_EXPLODE: begin
          if (expl_cnt_r == EXPL_W'(EXPLODE_CYCLES - 1)) begin
            state_r     <= ST_RESPAWN;
            exploding_r <= 1'b0;
          end else begin
            expl_cnt_r <= expl_cnt_r + EXPL_W'(1);
          end
        end
        ST_RESPAWN: begin
          x_r         <= SCREEN_WIDTH;
          hp_r        <= 3'(ENEMY_HP);
          move_cnt_r  <= MOVE_W'(0);
          expl_cnt_r  <= EXPL_W'(0);
          state_r     <= ST_ALIVE;
          alive_r     <= 1'b1;
          exploding_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_RESPAWN;
          alive_r     <= 1'b0;
          exploding_r <= 1'b0;
        end
      endcase
    end
  end

  assign topLeft_x_enemy = x_r;
  assign topLeft_y_enemy = 32'(SPAWN_Y);
  assign enemy_hp        = hp_r;
  assign enemy_alive     = alive_r;
  assign exploding       = exploding_r;
  assign hit_pulse       = hit_pulse_r;
  assign kill_pulse      = kill_pulse_r;

endmodule

// File: tb/tb_enemy_hit_manager.sv
// Self-checking bench for enemy_hit_manager: vector table, directed life-cycle
// sequences, and random stimulus against an age/countdown reference model.
module tb_enemy_hit_manager;
  localparam int HP = 3, DIV = 4, EXC = 8, SW = 640, SY = 200, WE = 64;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic restart_enemy = 1'b0;
  logic [2:0] coll = 3'b000;
  logic [2:0] air = 3'b000;
  logic signed [31:0] x;
  logic [31:0] y;
  logic [2:0] hp;
  logic alive, expl, hitp, killp;

  int total = 0;
  int bad = 0;

  enemy_hit_manager #(
    .ENEMY_HP(HP), .DIVIDER(DIV), .EXPLODE_CYCLES(EXC),
    .SCREEN_WIDTH(SW), .SPAWN_Y(SY), .WIDTH_ENEMY(WE)
  ) dut (
    .clk(clk), .resetN(resetN), .restart_enemy(restart_enemy),
    .collision_light_1(coll[0]), .collision_light_2(coll[1]), .collision_light_3(coll[2]),
    .in_air_1(air[0]), .in_air_2(air[1]), .in_air_3(air[2]),
    .topLeft_x_enemy(x), .topLeft_y_enemy(y), .enemy_hp(hp),
    .enemy_alive(alive), .exploding(expl), .hit_pulse(hitp), .kill_pulse(killp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetN = 1'b0; restart_enemy = 1'b0; coll = 3'b000; air = 3'b000;
    tick(); tick();
    resetN = 1'b1;
  endtask

  // Reference model: x derived from alive age, explosion as a countdown
  int m_phase;      // 0 alive, 1 exploding, 2 respawning
  int m_age, m_hp, m_left;
  bit [2:0] m_seen;
  bit m_hit, m_kill;

  function automatic int m_x();
    return SW - m_age / DIV;
  endfunction

  task automatic model_step();
    bit [2:0] nh;
    int n;
    nh = coll & air & ~m_seen;
    n = $countones(nh);
    m_hit = 1'b0; m_kill = 1'b0;
    if (!resetN || restart_enemy) begin
      m_seen = 3'b000; m_phase = 0; m_age = 0; m_hp = HP; m_left = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!air[k]) m_seen[k] = 1'b0;
        else if (coll[k]) m_seen[k] = 1'b1;
      end
      if (m_phase == 0) begin
        if (n > 0 && n >= m_hp) begin
          m_hp = 0; m_kill = 1'b1; m_phase = 1; m_left = EXC;
        end else begin
          if (n > 0) begin m_hp = m_hp - n; m_hit = 1'b1; end
          if (m_x() <= -WE) m_phase = 2;
          m_age++;
        end
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end else begin
        m_age = 0; m_hp = HP; m_phase = 0;
      end
    end
  endtask

  typedef struct {
    logic [2:0] c;
    logic [2:0] a;
    int hp;
    bit al, ex, h, k;
  } vec_t;

  vec_t vt[7];

  initial begin
    int cnt, cyc, pulses;

    vt[0] = '{c:3'b000, a:3'b001, hp:3, al:1'b1, ex:1'b0, h:1'b0, k:1'b0};
    vt[1] = '{c:3'b001, a:3'b001, hp:2, al:1'b1, ex:1'b0, h:1'b1, k:1'b0};
    vt[2] = '{c:3'b001, a:3'b001, hp:2, al:1'b1, ex:1'b0, h:1'b0, k:1'b0};
    vt[3] = '{c:3'b000, a:3'b000, hp:2, al:1'b1, ex:1'b0, h:1'b0, k:1'b0};
    vt[4] = '{c:3'b011, a:3'b011, hp:0, al:1'b0, ex:1'b1, h:1'b0, k:1'b1};
    vt[5] = '{c:3'b100, a:3'b100, hp:0, al:1'b0, ex:1'b1, h:1'b0, k:1'b0};
    vt[6] = '{c:3'b000, a:3'b000, hp:0, al:1'b0, ex:1'b1, h:1'b0, k:1'b0};

    // Reset values and first movement step
    do_reset();
    chk("reset_x", x, SW);
    chk("reset_y", y, SY);
    chk("reset_hp", hp, HP);
    chk("reset_alive", alive, 1);
    chk("reset_expl", expl, 0);
    chk("reset_pulses", hitp | killp, 0);
    tick(); tick(); tick();
    chk("x_before_step", x, SW);
    tick();
    chk("x_after_step", x, SW - 1);

    // Vector table
    do_reset();
    for (int i = 0; i < 7; i++) begin
      coll = vt[i].c; air = vt[i].a;
      tick();
      chk($sformatf("vec%0d_hp", i), hp, vt[i].hp);
      chk($sformatf("vec%0d_alive", i), alive, vt[i].al);
      chk($sformatf("vec%0d_expl", i), expl, vt[i].ex);
      chk($sformatf("vec%0d_hit", i), hitp, vt[i].h);
      chk($sformatf("vec%0d_kill", i), killp, vt[i].k);
    end

    // Held collision counts once
    do_reset();
    coll = 3'b001; air = 3'b001; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hitp) cnt++;
    end
    chk("held_hit_pulses", cnt, 1);
    chk("held_hp", hp, 2);

    // Triple hit kills, explosion length, respawn, latch blocks re-hit
    do_reset();
    coll = 3'b111; air = 3'b111;
    tick();
    chk("kill_pulse", killp, 1);
    chk("kill_no_hit", hitp, 0);
    chk("kill_hp", hp, 0);
    coll = 3'b000;
    cnt = expl ? 1 : 0;
    for (int i = 0; i < 20 && expl; i++) begin
      tick();
      if (expl) cnt++;
    end
    chk("explode_len", cnt, EXC);
    chk("respawn_not_alive", alive, 0);
    tick();
    chk("respawn_alive", alive, 1);
    chk("respawn_x", x, SW);
    chk("respawn_hp", hp, HP);
    coll = 3'b001;
    tick();
    chk("latched_no_pulse", hitp | killp, 0);
    chk("latched_hp", hp, HP);
    coll = 3'b000; air = 3'b110;
    tick();
    coll = 3'b001; air = 3'b111;
    tick();
    chk("refire_hit", hitp, 1);
    chk("refire_hp", hp, HP - 1);

    // Escape off the left edge
    do_reset();
    cyc = 0; pulses = 0;
    while (alive && cyc < 3000) begin
      tick();
      cyc++;
      if (hitp || killp) pulses++;
    end
    chk("escape_cycles", cyc, 704 * DIV + 1);
    chk("escape_x", x, -WE);
    chk("escape_pulses", pulses, 0);
    tick();
    chk("escape_alive", alive, 1);
    chk("escape_respawn_x", x, SW);

    // Restart mid-explosion
    do_reset();
    coll = 3'b111; air = 3'b111;
    tick();
    coll = 3'b000; air = 3'b000;
    tick(); tick();
    restart_enemy = 1'b1;
    tick();
    restart_enemy = 1'b0;
    chk("restart_alive", alive, 1);
    chk("restart_expl", expl, 0);
    chk("restart_x", x, SW);
    chk("restart_hp", hp, HP);
    tick();
    chk("restart_stays_alive", alive, 1);

    // Random stimulus against the reference model
    resetN = 1'b0; restart_enemy = 1'b0; coll = 3'b000; air = 3'b000;
    for (int i = 0; i < 4000; i++) begin
      if (i > 0) begin
        resetN = ($urandom_range(0, 299) != 0);
        restart_enemy = ($urandom_range(0, 199) == 0);
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range(0, 9) == 0) air[k] = ~air[k];
          coll[k] = air[k] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
        end
      end
      model_step();
      tick();
      chk("rnd_x", x, m_x());
      chk("rnd_hp", hp, m_hp);
      chk("rnd_alive", alive, m_phase == 0);
      chk("rnd_expl", expl, m_phase == 1);
      chk("rnd_hit", hitp, m_hit);
      chk("rnd_kill", killp, m_kill);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/enemy_hit_manager.md
# enemy_hit_manager

Target-side counterpart of the lightning projectile mover. It consumes per-projectile collision and in-flight flags, counts each projectile's hit exactly once, and tracks enemy hit points. It runs the enemy life cycle (advance left, explode, respawn) and drives the enemy position to the drawing and collision logic. It also emits score pulses to the game controller.

## Interface
- ENEMY_HP, 3: hit points at spawn (1..7).
- DIVIDER, 60_000: clocks per 1-pixel leftward step.
- EXPLODE_CYCLES, 25_000_000: clocks the explosion is shown.
- SCREEN_WIDTH, 640: spawn x coordinate.
- SPAWN_Y, 200: fixed enemy y coordinate.
- WIDTH_ENEMY, 64: enemy width; the enemy is off-screen when x <= -WIDTH_ENEMY.
- clk  in  1  system clock; the only clock.
- resetN  in  1  synchronous, active-low reset.
- restart_enemy  in  1  synchronous game restart, active-high; same effect as reset.
- collision_light_1..3  in  1 each  high while projectile k overlaps the enemy.
- in_air_1..3  in  1 each  high while projectile k is in flight.
- topLeft_x_enemy  out  32 signed  enemy x.
- topLeft_y_enemy  out  32  enemy y; always SPAWN_Y.
- enemy_hp  out  3  remaining hit points.
- enemy_alive  out  1  high in ALIVE.
- exploding  out  1  high in EXPLODE.
- hit_pulse  out  1  one-cycle pulse on any counted hit that does not kill.
- kill_pulse  out  1  one-cycle pulse on the killing hit.

## Operation
- States:
  - ALIVE: moves and takes hits.
  - EXPLODE: frozen, ignores hits.
  - RESPAWN: one cycle, reloads the enemy.
- Per-projectile hit latch hit_seen_k:
  - Set when collision_light_k && in_air_k.
  - Cleared when !in_air_k.
  - Updated in every state.
  - new_hit_k = collision_light_k && in_air_k && !hit_seen_k.
  - Effect: one projectile counts at most once per flight, and a projectile that passes through an explosion cannot hit the respawned enemy.
- ALIVE, hits:
  - n = number of new_hit_k asserted this cycle (0..3).
  - If n >= enemy_hp: enemy_hp <= 0, kill_pulse, go to EXPLODE; that cycle's movement is discarded.
  - Else if n > 0: enemy_hp <= enemy_hp - n, hit_pulse.
- ALIVE, movement:
  - move_cnt increments every cycle.
  - At move_cnt == DIVIDER-1: move_cnt <= 0 and x <= x - 1.
  - If x <= -WIDTH_ENEMY with no kill this cycle, go to RESPAWN (escape, no pulse).
- EXPLODE:
  - expl_cnt counts 0..EXPLODE_CYCLES-1.
  - At terminal count, go to RESPAWN.
  - Collisions produce no pulses and no hp change; latches still update.
- RESPAWN:
  - x <= SCREEN_WIDTH, enemy_hp <= ENEMY_HP, move_cnt <= 0, expl_cnt <= 0.
  - Next state: ALIVE.
- Reset / restart:
  - resetN low or restart_enemy high: state ALIVE, x = SCREEN_WIDTH, y = SPAWN_Y, enemy_hp = ENEMY_HP, enemy_alive = 1, exploding = 0, pulses 0, counters 0, latches 0.
  - resetN has priority over restart_enemy.
  - Either one aborts an explosion or movement mid-way.
- Arithmetic:
  - x is 32-bit two's complement; the off-screen compare is signed.
  - hp subtraction uses 3 bits, guarded by the n >= hp compare, so it never wraps.

## Timing
- All outputs are registered.
- A collision sampled at edge t updates enemy_hp and pulses at edge t; the values are visible in cycle t+1.
- Pulses are exactly one cycle wide.
- enemy_alive and exploding change on the same edge as the state.
- Kill-to-alive latency: EXPLODE_CYCLES + 1 cycles. enemy_alive rises on the edge after the RESPAWN cycle.
- Movement period: exactly DIVIDER cycles per pixel.
- Simultaneous events:
  - Kill plus off-screen in the same cycle: kill wins.
  - Collision falling together with in_air: the hit counts if both were high at the edge.

## Test plan
All scenarios use DIVIDER=4, EXPLODE_CYCLES=8, ENEMY_HP=3.

- Reset check: after resetN is released, x = 640, hp = 3, enemy_alive = 1, and x = 639 after 4 cycles.
- Held collision: in_air_1 high with collision_light_1 held 20 cycles -> one hit_pulse, hp = 2.
- Kill and respawn: collision_light_1..3 plus in_air_1..3 all asserted in one cycle from hp = 3 ->
  - kill_pulse only; hp = 0; exploding = 1 for 8 cycles.
  - Then RESPAWN: x = 640, hp = 3.
  - Then enemy_alive = 1.
- Latch blocks re-hit: projectile 1 re-fired without in_air_1 ever dropping, collides after respawn -> no pulse. After in_air_1 drops and re-rises, a new collision -> hit_pulse.
- Escape: no hits for 704×4 cycles -> x reaches -64, RESPAWN with no pulses, x = 640.
- Restart mid-explosion: restart_enemy pulsed 3 cycles into EXPLODE -> next cycle ALIVE, x = 640, hp = 3, exploding = 0.
